// File: rtl/pc_seq_if.sv
// Fetch, resolution and status bundle between pc_sequencer and the core.
// PC_BRANCH_STATS_EN adds the branch statistics counters.
interface pc_seq_if #(
  parameter int STAT_W = 16
);
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        exec_done;
  logic        BEQ;
  logic        BNE;
  logic        Zero;
  logic        Jump;
  logic [25:0] jump_index;
  logic [31:0] BranchVal;
  logic        halt;
  logic [31:0] pc;
  logic        branch_taken;
  logic        halted;
`ifdef PC_BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt;
  logic [STAT_W-1:0] branch_cnt;

  modport master (
    output fetch_valid, fetch_addr, pc,
    output branch_taken, halted,
    output taken_cnt, branch_cnt,
    input  fetch_ready, exec_done,
    input  BEQ, BNE, Zero, Jump,
    input  jump_index, BranchVal, halt
  );

  modport slave (
    input  fetch_valid, fetch_addr, pc,
    input  branch_taken, halted,
    input  taken_cnt, branch_cnt,
    output fetch_ready, exec_done,
    output BEQ, BNE, Zero, Jump,
    output jump_index, BranchVal, halt
  );
`else
  modport master (
    output fetch_valid, fetch_addr, pc,
    output branch_taken, halted,
    input  fetch_ready, exec_done,
    input  BEQ, BNE, Zero, Jump,
    input  jump_index, BranchVal, halt
  );

  modport slave (
    input  fetch_valid, fetch_addr, pc,
    input  branch_taken, halted,
    output fetch_ready, exec_done,
    output BEQ, BNE, Zero, Jump,
    output jump_index, BranchVal, halt
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// PC controller: fetch handshake, exec wait, next-PC select, sticky halt.
// PC_BRANCH_STATS_EN enables saturating taken/executed branch counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STAT_W   = 16
) (
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, FETCH, EXEC, HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        bt_q, bt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        taken;
  logic        commit;
  logic        br_commit;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + (bus.BranchVal << 2);
  assign j_tgt    = {pc_plus4[31:28], bus.jump_index, 2'b00};
  assign taken    = (bus.BEQ & bus.Zero) | (bus.BNE & ~bus.Zero);
  assign commit   = (state_q == EXEC) & bus.exec_done;
  assign br_commit = commit & ~bus.halt & ~bus.Jump
                   & (bus.BEQ | bus.BNE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bt_d    = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (bus.fetch_ready) state_d = EXEC;
      EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
            if (bus.Jump) begin
              pc_d = j_tgt;
            end else if (taken) begin
              pc_d = br_tgt;
              bt_d = 1'b1;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
      end
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      bt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bt_q    <= bt_d;
    end
  end

  assign bus.fetch_valid  = (state_q == FETCH);
  assign bus.fetch_addr   = pc_q;
  assign bus.pc           = pc_q;
  assign bus.branch_taken = bt_q;
  assign bus.halted       = (state_q == HALT);

`ifdef PC_BRANCH_STATS_EN
  logic [STAT_W-1:0] tcnt_q, bcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      bcnt_q <= '0;
    end else if (br_commit) begin
      if (~&bcnt_q) bcnt_q <= bcnt_q + 1'b1;
      if (taken && ~&tcnt_q) tcnt_q <= tcnt_q + 1'b1;
    end
  end

  assign bus.taken_cnt  = tcnt_q;
  assign bus.branch_cnt = bcnt_q;
`else
  logic unused_br;
  assign unused_br = br_commit;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: instruction table plus
// hand sequences for stalls, halt and asynchronous reset.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  pc_seq_if #(.STAT_W(2)) bus ();

  pc_sequencer #(
    .RESET_PC(32'h0000_0000),
    .STAT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        beq;
    logic        bne;
    logic        zero;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] bv;
    logic [31:0] exp_pc;
    logic        exp_bt;
  } vec_t;

  vec_t tbl[12];
  vec_t seqv;
  logic [31:0] cur_pc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_ctrl();
    bus.exec_done  = 1'b0;
    bus.BEQ        = 1'b0;
    bus.BNE        = 1'b0;
    bus.Zero       = 1'b0;
    bus.Jump       = 1'b0;
    bus.halt       = 1'b0;
    bus.jump_index = '0;
    bus.BranchVal  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter with the DUT in FETCH; leave in FETCH of the next instruction.
  task automatic run(input vec_t v, input int n);
    chk($sformatf("fv_fetch[%0d]", n), 32'(bus.fetch_valid), 32'd1);
    chk($sformatf("addr[%0d]", n), bus.fetch_addr, cur_pc);
    bus.fetch_ready = 1'b1;
    tick();
    bus.fetch_ready = 1'b0;
    chk($sformatf("fv_exec[%0d]", n), 32'(bus.fetch_valid), 32'd0);
    chk($sformatf("bt_low[%0d]", n), 32'(bus.branch_taken), 32'd0);
    bus.BEQ        = v.beq;
    bus.BNE        = v.bne;
    bus.Zero       = v.zero;
    bus.Jump       = v.jmp;
    bus.jump_index = v.idx;
    bus.BranchVal  = v.bv;
    bus.exec_done  = 1'b1;
    tick();
    clr_ctrl();
    chk($sformatf("pc[%0d]", n), bus.pc, v.exp_pc);
    chk($sformatf("bt[%0d]", n), 32'(bus.branch_taken), 32'(v.exp_bt));
    cur_pc = v.exp_pc;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 26'h0,   32'h0,         32'h0000_0004, 0};
    tbl[1]  = '{0, 0, 0, 0, 26'h0,   32'h0,         32'h0000_0008, 0};
    tbl[2]  = '{0, 0, 0, 1, 26'h10,  32'h0,         32'h0000_0040, 0};
    tbl[3]  = '{1, 0, 1, 0, 26'h0,   32'hFFFF_FFFE, 32'h0000_003C, 1};
    tbl[4]  = '{0, 0, 0, 1, 26'h10,  32'h0,         32'h0000_0040, 0};
    tbl[5]  = '{1, 0, 0, 0, 26'h0,   32'hFFFF_FFFE, 32'h0000_0044, 0};
    tbl[6]  = '{0, 1, 0, 0, 26'h0,   32'h03FF_FFF2, 32'h1000_0010, 1};
    tbl[7]  = '{0, 1, 0, 1, 26'h100, 32'h0000_0008, 32'h1000_0400, 0};
    tbl[8]  = '{1, 1, 0, 0, 26'h0,   32'h0000_0001, 32'h1000_0408, 1};
    tbl[9]  = '{0, 1, 1, 0, 26'h0,   32'h0000_0010, 32'h1000_040C, 0};
    tbl[10] = '{1, 0, 1, 0, 26'h0,   32'h3BFF_FEFB, 32'hFFFF_FFFC, 1};
    tbl[11] = '{0, 0, 0, 0, 26'h0,   32'h0,         32'h0000_0000, 0};
    seqv    = '{0, 0, 0, 0, 26'h0,   32'h0,         32'h0000_0004, 0};

    bus.fetch_ready = 1'b0;
    clr_ctrl();
    rst = 1'b1;
    tick();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_addr", bus.fetch_addr, 32'h0);
    chk("rst_fv", 32'(bus.fetch_valid), 32'd0);
    chk("rst_bt", 32'(bus.branch_taken), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
`ifdef PC_BRANCH_STATS_EN
    chk("rst_tcnt", 32'(bus.taken_cnt), 32'd0);
    chk("rst_bcnt", 32'(bus.branch_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_fv", 32'(bus.fetch_valid), 32'd0);
    tick();
    cur_pc = 32'h0;

    for (int i = 0; i < 12; i++) run(tbl[i], i);

`ifdef PC_BRANCH_STATS_EN
    chk("sat_tcnt", 32'(bus.taken_cnt), 32'd3);
    chk("sat_bcnt", 32'(bus.branch_cnt), 32'd3);
`endif

    // Stall in FETCH with stray exec_done/Jump
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.exec_done = 1'b1;
      bus.Jump      = 1'b1;
      bus.jump_index = 26'h3FF;
      tick();
      chk($sformatf("stall_fv[%0d]", i), 32'(bus.fetch_valid), 32'd1);
      chk($sformatf("stall_addr[%0d]", i), bus.fetch_addr, 32'h0);
    end
    clr_ctrl();
    run(seqv, 100);

    // Halt at pc 4, then inputs ignored
    bus.fetch_ready = 1'b1;
    tick();
    bus.halt      = 1'b1;
    bus.Jump      = 1'b1;
    bus.exec_done = 1'b1;
    tick();
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_pc", bus.pc, 32'h4);
    chk("halt_fv", 32'(bus.fetch_valid), 32'd0);
    clr_ctrl();
    for (int i = 0; i < 3; i++) begin
      bus.fetch_ready = 1'b1;
      bus.exec_done   = 1'b1;
      bus.BEQ         = 1'b1;
      bus.Zero        = 1'b1;
      bus.BranchVal   = 32'h10;
      tick();
      chk($sformatf("hold_halted[%0d]", i), 32'(bus.halted), 32'd1);
      chk($sformatf("hold_pc[%0d]", i), bus.pc, 32'h4);
      chk($sformatf("hold_fv[%0d]", i), 32'(bus.fetch_valid), 32'd0);
      chk($sformatf("hold_bt[%0d]", i), 32'(bus.branch_taken), 32'd0);
    end
    clr_ctrl();
    bus.fetch_ready = 1'b0;

    // Asynchronous reset mid-HALT
    rst = 1'b1;
    #1;
    chk("arst_h_pc", bus.pc, 32'h0);
    chk("arst_h_halted", 32'(bus.halted), 32'd0);
    chk("arst_h_fv", 32'(bus.fetch_valid), 32'd0);
`ifdef PC_BRANCH_STATS_EN
    chk("arst_tcnt", 32'(bus.taken_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    cur_pc = 32'h0;
    run(seqv, 101);

    // Asynchronous reset mid-EXEC
    bus.fetch_ready = 1'b1;
    tick();
    bus.fetch_ready = 1'b0;
    chk("exec_pc", bus.pc, 32'h4);
    rst = 1'b1;
    #1;
    chk("arst_e_pc", bus.pc, 32'h0);
    chk("arst_e_fv", 32'(bus.fetch_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_idle_fv", 32'(bus.fetch_valid), 32'd0);
    tick();
    chk("rel_fetch_fv", 32'(bus.fetch_valid), 32'd1);
    chk("rel_fetch_addr", bus.fetch_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter controller that sequences the instruction-fetch / execute loop of the MIPS core. Holds the PC, issues one fetch per instruction over a valid/ready handshake, waits for the datapath to report completion, then selects the next PC: halt, jump, conditional branch (BEQ/BNE on Zero) or sequential. It sits between instruction memory and the branch/next-PC datapath and owns all PC updates.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STAT_W, 16, width of branch statistics counters (only used with the stats macro).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_valid  out  1  fetch request to instruction memory.
- fetch_addr  out  32  address of requested instruction (equals pc).
- fetch_ready  in  1  memory accepts fetch; transfer when fetch_valid & fetch_ready.
- exec_done  in  1  datapath finished current instruction; resolution inputs valid this cycle.
- BEQ  in  1  current instruction is beq.
- BNE  in  1  current instruction is bne.
- Zero  in  1  ALU zero flag.
- Jump  in  1  current instruction is j.
- jump_index  in  26  instruction[25:0].
- BranchVal  in  32  sign-extended branch offset (words).
- halt  in  1  current instruction is halt.
- pc  out  32  current PC.
- branch_taken  out  1  one-cycle pulse when a branch redirect is committed.
- halted  out  1  core stopped.
- taken_cnt  out  STAT_W  taken branches (macro only).
- branch_cnt  out  STAT_W  executed BEQ/BNE (macro only).

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: one cycle after reset release, then FETCH unconditionally.
- FETCH: fetch_valid=1, fetch_addr=pc held stable until fetch_ready=1; then EXEC.
- EXEC: fetch_valid=0; wait for exec_done. On exec_done, PC updates on that edge, next state FETCH (or HALT).
- Next-PC priority on exec_done: halt > Jump > taken branch > sequential.
  - pc_plus4 = pc + 4.
  - taken = (BEQ & Zero) | (BNE & ~Zero).
  - branch target = pc_plus4 + (BranchVal << 2), mod 2^32.
  - jump target = {pc_plus4[31:28], jump_index, 2'b00}.
  - halt: pc unchanged, state HALT, halted=1.
- HALT: sticky; all inputs ignored; only rst leaves it.
- BEQ and BNE both high: taken computed by the formula above (always taken); branch_cnt increments once.
- fetch_ready outside FETCH, exec_done outside EXEC: ignored.
- All arithmetic 32-bit, wrap-around silently (pc 32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: pc=RESET_PC, state=IDLE, fetch_valid=0, fetch_addr=RESET_PC, branch_taken=0, halted=0, counters=0.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous), and any in-flight fetch is abandoned.
- fetch_valid and halted decode from the registered state. fetch_addr is the registered pc. branch_taken is registered.
- Minimum 2 cycles per instruction: FETCH with ready, then EXEC with done.
- The new pc is visible on fetch_addr in the FETCH cycle after the exec_done edge.
- branch_taken is high in the cycle after the committing exec_done edge, for exactly one cycle.

## Configuration
- PC_BRANCH_STATS_EN defined: taken_cnt and branch_cnt ports exist.
  - branch_cnt increments on each exec_done with BEQ|BNE and no halt/Jump.
  - taken_cnt increments when such a branch is taken.
  - Both saturate at all-ones, and both reset to 0.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with RESET_PC=0, fetch_ready=1, exec_done=1, no control -> fetch_addr sequence 0,4,8 on successive FETCH cycles, with fetch_valid high every other cycle.
- pc=0x40, BEQ=1, Zero=1, BranchVal=32'hFFFF_FFFE -> next fetch_addr 0x3C and branch_taken pulses once; with Zero=0 -> 0x44 and no pulse.
- pc=0x1000_0010, Jump=1, jump_index=26'h0000_100 -> fetch_addr 0x1000_0400. Jump with BNE=1 and Zero=0 simultaneously -> jump wins.
- fetch_ready held low 5 cycles in FETCH -> fetch_valid stays 1 with fetch_addr stable; exec_done pulses during FETCH have no effect.
- halt=1 with exec_done -> halted=1 next cycle and pc frozen; later fetch_ready/exec_done are ignored; rst mid-HALT or mid-EXEC -> pc=RESET_PC and state IDLE immediately.
- With PC_BRANCH_STATS_EN and STAT_W=2: 5 taken branches -> taken_cnt=3 (saturated) and branch_cnt=3.
